apb_req_arbiter: RTL and testbench
==================================

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT, default 15, the number of ACCESS cycles without PREADY before a transfer is aborted (legal range 1..255).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 PCLK  in  1  clock; all state changes on the rising edge.
REQ-004 PRESETn  in  1  asynchronous active-low reset.
REQ-005 req_i  in  2  per-requester request; bit n belongs to requester n; held high until ack_o[n].
REQ-006 wr_i  in  2  per-requester direction: 1 = write, 0 = read.
REQ-007 addr0_i, addr1_i  in  9 each  request address; bit 8 selects the slave (0 = slave 1, 1 = slave 2); bits 7:0 are the slave offset.
REQ-008 wdata0_i, wdata1_i  in  32 each  write data.
REQ-009 ack_o  out  2  one-cycle completion pulse per requester.
REQ-010 rdata_o  out  32  read data; valid while any ack_o bit is high.
REQ-011 err_o  out  1  error flag; valid while any ack_o bit is high.
REQ-012 PSEL1, PSEL2  out  1 each  APB slave selects.
REQ-013 PENABLE  out  1  APB enable.
REQ-014 PWRITE  out  1  APB direction.
REQ-015 PADDR  out  8  APB address, equal to request address bits 7:0.
REQ-016 PWDATA  out  32  APB write data.
REQ-017 PRDATA1, PRDATA2  in  32 each  read data from slave 1 and slave 2.
REQ-018 PREADY  in  1  ready from the selected slave.
REQ-019 PSLVERR  in  1  error from the selected slave.

Function
REQ-020 The FSM SHALL have three states: IDLE, SETUP and ACCESS.
REQ-021 In IDLE, on a rising edge where the masked request (req_i AND NOT ack_o) is non-zero, the block SHALL latch the winner's direction, address and write data, and SHALL move to SETUP.
REQ-022 Arbitration SHALL be round-robin: if both requesters request, the one not granted last wins; a single request always wins.
REQ-023 In SETUP, the block SHALL drive the PSEL matching address bit 8, with PENABLE=0, and SHALL move to ACCESS unconditionally after one cycle.
REQ-024 In ACCESS, the block SHALL drive PENABLE=1; PSEL, PWRITE, PADDR and PWDATA SHALL stay stable from SETUP through the end of ACCESS.
REQ-025 In ACCESS with PREADY=1, the block SHALL move to IDLE.
  - On the same edge it SHALL register: ack_o[winner]=1, err_o=PSLVERR, rdata_o = PRDATA of the selected slave for a read, or 0 for a write.
REQ-026 In ACCESS with PREADY=0, the block SHALL increment the wait counter.
  - When the counter reaches TIMEOUT, the block SHALL move to IDLE with ack_o[winner]=1, err_o=1 and rdata_o=0.
REQ-027 The wait counter SHALL be 8 bits wide and SHALL clear on entry to SETUP.
REQ-028 PSLVERR and PRDATA SHALL be ignored unless the block is in ACCESS and PREADY=1.
REQ-029 ack_o, rdata_o and err_o SHALL be high or valid for exactly one cycle, then return to 0.
REQ-030 In IDLE, PSEL1, PSEL2 and PENABLE SHALL be 0; PADDR, PWDATA and PWRITE SHALL hold their last values.
REQ-031 Timing SHALL be as follows:
  - Minimum latency from a sampled request to ack is 3 cycles (IDLE sample, SETUP, ACCESS).
  - A new transfer MAY be sampled in the same cycle ack_o is high; the acked requester is masked in that cycle.
REQ-032 A change on req_i, wr_i, address or data inputs during SETUP or ACCESS SHALL NOT affect the transfer in progress.

Reset
REQ-033 While PRESETn=0, the block SHALL immediately (asynchronously) force the following values:
  - state = IDLE, wait counter = 0, last-grant = requester 1 (so requester 0 wins the first tie);
  - all outputs = 0: ack_o, rdata_o, err_o, PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA.
REQ-034 A reset asserted during SETUP or ACCESS SHALL abort the transfer with no ack; after release, the block SHALL restart arbitration from IDLE.

Verification
REQ-035 Write to slave 1: req_i=01, wr_i=01, addr0=0x00C, wdata0=9, PREADY=1 -> PSEL1=1 with PENABLE=0, then PENABLE=1 with PADDR=0x0C and PWDATA=9; ack_o=01 3 cycles after the sample; err_o=0.
REQ-036 Read from slave 2 with wait states: req_i=10, wr_i=00, addr1=0x116, PRDATA2=35, PREADY low for 2 ACCESS cycles -> PSEL2=1, PADDR=0x16; ack_o=10 with rdata_o=35 5 cycles after the sample.
REQ-037 Contention: req_i=11 held continuously after reset -> grants in order 0,1,0,1; each ack is a single-cycle pulse; no cycle has PSEL1 and PSEL2 both high.
REQ-038 Timeout and slave error:
  - TIMEOUT=15 with PREADY stuck at 0 -> ack with err_o=1 and rdata_o=0 after 15 ACCESS cycles, then IDLE.
  - A separate transfer with PSLVERR=1 and PREADY=1 -> err_o=1.
REQ-039 Reset mid-ACCESS: PRESETn=0 asserted between edges -> all outputs 0 immediately and no ack; after release with req_i=01 -> a normal transfer from IDLE.

Source files
------------

// File: rtl/apb_req_arbiter_if.sv
// APB bus bundle between the two-requester arbiter (master) and its
// two slaves. Slave-side return signals are shared; the arbiter picks
// PRDATA1 or PRDATA2 from its own slave select.
interface apb_req_arbiter_if;
  logic        PSEL1;
  logic        PSEL2;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA1;
  logic [31:0] PRDATA2;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA1, PRDATA2, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA1, PRDATA2, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin arbiter feeding a single APB master with two
// slave selects. One transfer at a time: IDLE -> SETUP -> ACCESS -> IDLE,
// with a wait-state timeout that completes the transfer with an error.
// All bus and completion outputs are registered.
module apb_req_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [1:0]  req_i,
  input  logic [1:0]  wr_i,
  input  logic [8:0]  addr0_i,
  input  logic [8:0]  addr1_i,
  input  logic [31:0] wdata0_i,
  input  logic [31:0] wdata1_i,
  output logic [1:0]  ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  apb_req_arbiter_if.master apb
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t      state_q;
  logic [7:0]  wait_q;
  logic        last_q;     // requester granted most recently
  logic        win_q;      // requester owning the transfer in flight
  logic        psel1_q;
  logic        psel2_q;
  logic        penable_q;
  logic        pwrite_q;
  logic [7:0]  paddr_q;
  logic [31:0] pwdata_q;
  logic [1:0]  ack_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [1:0]  masked_d;
  logic        winner_d;
  logic [8:0]  sel_addr_d;
  logic [31:0] sel_wdata_d;
  logic [7:0]  wait_d;
  logic [31:0] sel_rdata_d;

  // Arbitration and operand selection for the next grant.
  always_comb begin
    // NOTE: every signal gets a value on every pass so no latch is inferred.
    masked_d    = req_i & ~ack_q;   // a requester being acked cannot re-win this cycle
    winner_d    = (masked_d == 2'b11) ? ~last_q : masked_d[1];
    sel_addr_d  = winner_d ? addr1_i  : addr0_i;
    sel_wdata_d = winner_d ? wdata1_i : wdata0_i;
    wait_d      = wait_q + 8'd1;
    sel_rdata_d = psel2_q ? apb.PRDATA2 : apb.PRDATA1;
  end

  // Transfer FSM with registered bus and completion outputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      last_q    <= 1'b1;            // requester 0 wins the first tie
      win_q     <= 1'b0;
      psel1_q   <= 1'b0;
      psel2_q   <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      ack_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every branch reads pre-edge state.
      ack_q   <= '0;                // completion outputs are one-cycle pulses
      rdata_q <= '0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|masked_d) begin
            win_q    <= winner_d;
            last_q   <= winner_d;
            pwrite_q <= wr_i[winner_d];
            paddr_q  <= sel_addr_d[7:0];
            pwdata_q <= sel_wdata_d;
            psel1_q  <= ~sel_addr_d[8];
            psel2_q  <= sel_addr_d[8];
            wait_q   <= '0;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (apb.PREADY) begin
            ack_q[win_q] <= 1'b1;
            err_q        <= apb.PSLVERR;
            rdata_q      <= pwrite_q ? '0 : sel_rdata_d;
            psel1_q      <= 1'b0;
            psel2_q      <= 1'b0;
            penable_q    <= 1'b0;
            state_q      <= IDLE;
          end else if (wait_d == TIMEOUT_C) begin
            ack_q[win_q] <= 1'b1;
            err_q        <= 1'b1;
            psel1_q      <= 1'b0;
            psel2_q      <= 1'b0;
            penable_q    <= 1'b0;
            state_q      <= IDLE;
          end else begin
            wait_q <= wait_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign apb.PSEL1   = psel1_q;
  assign apb.PSEL2   = psel2_q;
  assign apb.PENABLE = penable_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;
  assign ack_o       = ack_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed scenarios for single transfers, wait
// states, contention, timeout, slave error and mid-transfer reset, then a
// randomized run scored against a transaction-level round-robin model.
module tb_apb_req_arbiter;

  logic        PCLK    = 1'b0;
  logic        PRESETn = 1'b1;
  logic [1:0]  req_i;
  logic [1:0]  wr_i;
  logic [8:0]  addr0_i;
  logic [8:0]  addr1_i;
  logic [31:0] wdata0_i;
  logic [31:0] wdata1_i;
  logic [1:0]  ack_o;
  logic [31:0] rdata_o;
  logic        err_o;

  int n_cmp = 0;
  int n_bad = 0;

  apb_req_arbiter_if apb ();

  apb_req_arbiter #(.TIMEOUT(15)) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .req_i    (req_i),
    .wr_i     (wr_i),
    .addr0_i  (addr0_i),
    .addr1_i  (addr1_i),
    .wdata0_i (wdata0_i),
    .wdata1_i (wdata1_i),
    .ack_o    (ack_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .apb      (apb)
  );

  always #5 PCLK = ~PCLK;

  // {PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA}
  function automatic logic [43:0] bus_obs();
    return {apb.PSEL1, apb.PSEL2, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA};
  endfunction

  function automatic logic [43:0] bus_exp(input logic sel2, input logic en,
                                          input logic wr, input logic [7:0] a,
                                          input logic [31:0] wd);
    return {~sel2, sel2, en, wr, a, wd};
  endfunction

  // {ack_o, err_o, rdata_o}
  function automatic logic [34:0] cpl_obs();
    return {ack_o, err_o, rdata_o};
  endfunction

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic do_reset();
    req_i = 2'b00;
    apb.PREADY = 1'b0;
    apb.PSLVERR = 1'b0;
    @(posedge PCLK);
    #2 PRESETn = 1'b0;
    @(posedge PCLK);
    @(posedge PCLK);
    #3 PRESETn = 1'b1;
  endtask

  task automatic test_reset();
    req_i = '0; wr_i = '0; addr0_i = '0; addr1_i = '0;
    wdata0_i = '0; wdata1_i = '0;
    apb.PRDATA1 = '0; apb.PRDATA2 = '0; apb.PREADY = 1'b0; apb.PSLVERR = 1'b0;
    #1 PRESETn = 1'b0;
    #1;
    n_cmp++;
    if ({cpl_obs(), bus_obs()} !== 79'd0) begin
      n_bad++;
      $display("FAIL reset_async: got %h required 0", {cpl_obs(), bus_obs()});
    end
    @(posedge PCLK);
    @(posedge PCLK);
    #3 PRESETn = 1'b1;
    tick();
    n_cmp++;
    if ({cpl_obs(), bus_obs()} !== 79'd0) begin
      n_bad++;
      $display("FAIL reset_idle: got %h required 0", {cpl_obs(), bus_obs()});
    end
  endtask

  task automatic test_write_s1();
    req_i = 2'b01; wr_i = 2'b01; addr0_i = 9'h00C; wdata0_i = 32'd9;
    apb.PREADY = 1'b1; apb.PSLVERR = 1'b0; apb.PRDATA1 = 32'hDEAD_BEEF;
    tick();
    n_cmp++;
    if (bus_obs() !== bus_exp(1'b0, 1'b0, 1'b1, 8'h0C, 32'd9)) begin
      n_bad++;
      $display("FAIL wr_setup: got %h required %h", bus_obs(), bus_exp(1'b0, 1'b0, 1'b1, 8'h0C, 32'd9));
    end
    tick();
    n_cmp++;
    if (bus_obs() !== bus_exp(1'b0, 1'b1, 1'b1, 8'h0C, 32'd9)) begin
      n_bad++;
      $display("FAIL wr_access: got %h required %h", bus_obs(), bus_exp(1'b0, 1'b1, 1'b1, 8'h0C, 32'd9));
    end
    tick();
    n_cmp++;
    if (cpl_obs() !== {2'b01, 1'b0, 32'd0}) begin
      n_bad++;
      $display("FAIL wr_ack: got %h required %h", cpl_obs(), {2'b01, 1'b0, 32'd0});
    end
    n_cmp++;
    if (bus_obs() !== {3'b000, 1'b1, 8'h0C, 32'd9}) begin
      n_bad++;
      $display("FAIL wr_idle_hold: got %h required %h", bus_obs(), {3'b000, 1'b1, 8'h0C, 32'd9});
    end
    req_i = 2'b00;
    tick();
    n_cmp++;
    if (cpl_obs() !== 35'd0) begin
      n_bad++;
      $display("FAIL wr_ack_pulse: got %h required 0", cpl_obs());
    end
  endtask

  task automatic test_read_wait_s2();
    req_i = 2'b10; wr_i = 2'b00; addr1_i = 9'h116; wdata1_i = 32'h0000_1234;
    apb.PRDATA2 = 32'd35; apb.PRDATA1 = 32'd77;
    apb.PREADY = 1'b0; apb.PSLVERR = 1'b1;     // error while not ready is ignored
    tick();
    n_cmp++;
    if (bus_obs() !== bus_exp(1'b1, 1'b0, 1'b0, 8'h16, 32'h1234)) begin
      n_bad++;
      $display("FAIL rd_setup: got %h required %h", bus_obs(), bus_exp(1'b1, 1'b0, 1'b0, 8'h16, 32'h1234));
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({ack_o, bus_obs()} !== {2'b00, bus_exp(1'b1, 1'b1, 1'b0, 8'h16, 32'h1234)}) begin
        n_bad++;
        $display("FAIL rd_wait%0d: got %h required %h", i, {ack_o, bus_obs()},
                 {2'b00, bus_exp(1'b1, 1'b1, 1'b0, 8'h16, 32'h1234)});
      end
    end
    apb.PREADY = 1'b1; apb.PSLVERR = 1'b0;
    tick();
    n_cmp++;
    if (cpl_obs() !== {2'b10, 1'b0, 32'd35}) begin
      n_bad++;
      $display("FAIL rd_ack: got %h required %h", cpl_obs(), {2'b10, 1'b0, 32'd35});
    end
    req_i = 2'b00; apb.PREADY = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] order [4];
    int acks;
    int overlap;
    logic prev_ack;
    order = '{2'b01, 2'b10, 2'b01, 2'b10};
    acks = 0; overlap = 0; prev_ack = 1'b0;
    do_reset();
    req_i = 2'b11; wr_i = 2'b10; addr0_i = 9'h005; addr1_i = 9'h1A0;
    wdata0_i = 32'h5; wdata1_i = 32'hA0;
    apb.PREADY = 1'b1; apb.PSLVERR = 1'b0;
    for (int c = 0; c < 40 && acks < 4; c++) begin
      tick();
      if (apb.PSEL1 && apb.PSEL2) overlap++;
      if (ack_o != 2'b00) begin
        n_cmp++;
        if (ack_o !== order[acks]) begin
          n_bad++;
          $display("FAIL rr_grant%0d: got %b required %b", acks, ack_o, order[acks]);
        end
        n_cmp++;
        if (prev_ack !== 1'b0) begin
          n_bad++;
          $display("FAIL rr_pulse%0d: ack high on consecutive cycles", acks);
        end
        acks++;
        prev_ack = 1'b1;
      end else begin
        prev_ack = 1'b0;
      end
    end
    req_i = 2'b00;
    n_cmp++;
    if (acks !== 4) begin
      n_bad++;
      $display("FAIL rr_count: got %0d acks required 4", acks);
    end
    n_cmp++;
    if (overlap !== 0) begin
      n_bad++;
      $display("FAIL rr_psel_overlap: got %0d cycles required 0", overlap);
    end
    tick();
  endtask

  task automatic test_timeout();
    int c;
    req_i = 2'b01; wr_i = 2'b00; addr0_i = 9'h033;
    apb.PREADY = 1'b0; apb.PSLVERR = 1'b0; apb.PRDATA1 = 32'h1111_2222;
    for (c = 1; c <= 40; c++) begin
      tick();
      if (ack_o != 2'b00) break;
    end
    n_cmp++;
    if (c !== 17) begin
      n_bad++;
      $display("FAIL to_latency: got %0d cycles required 17", c);
    end
    n_cmp++;
    if (cpl_obs() !== {2'b01, 1'b1, 32'd0}) begin
      n_bad++;
      $display("FAIL to_ack: got %h required %h", cpl_obs(), {2'b01, 1'b1, 32'd0});
    end
    n_cmp++;
    if ({apb.PSEL1, apb.PSEL2, apb.PENABLE} !== 3'b000) begin
      n_bad++;
      $display("FAIL to_idle: got %b required 000", {apb.PSEL1, apb.PSEL2, apb.PENABLE});
    end
    req_i = 2'b00;
    tick();
  endtask

  task automatic test_slverr();
    req_i = 2'b10; wr_i = 2'b00; addr1_i = 9'h0AB; wdata1_i = 32'h0;
    apb.PRDATA1 = 32'hCAFE_0001; apb.PRDATA2 = 32'h0BAD_0002;
    apb.PREADY = 1'b1; apb.PSLVERR = 1'b1;
    tick();
    n_cmp++;
    if (bus_obs() !== bus_exp(1'b0, 1'b0, 1'b0, 8'hAB, 32'h0)) begin
      n_bad++;
      $display("FAIL se_setup: got %h required %h", bus_obs(), bus_exp(1'b0, 1'b0, 1'b0, 8'hAB, 32'h0));
    end
    tick();
    tick();
    n_cmp++;
    if (cpl_obs() !== {2'b10, 1'b1, 32'hCAFE_0001}) begin
      n_bad++;
      $display("FAIL se_ack: got %h required %h", cpl_obs(), {2'b10, 1'b1, 32'hCAFE_0001});
    end
    req_i = 2'b00; apb.PSLVERR = 1'b0; apb.PREADY = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    int seen;
    seen = 0;
    req_i = 2'b10; wr_i = 2'b10; addr1_i = 9'h1C3; wdata1_i = 32'hFEED_F00D;
    apb.PREADY = 1'b0; apb.PSLVERR = 1'b0;
    tick();
    tick();
    tick();
    #3 PRESETn = 1'b0;
    #1;
    n_cmp++;
    if ({cpl_obs(), bus_obs()} !== 79'd0) begin
      n_bad++;
      $display("FAIL rst_mid_async: got %h required 0", {cpl_obs(), bus_obs()});
    end
    req_i = 2'b01; wr_i = 2'b00; addr0_i = 9'h042; wdata0_i = 32'h0;
    apb.PREADY = 1'b1; apb.PRDATA1 = 32'h0000_4242;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (ack_o != 2'b00) seen++;
    end
    #3 PRESETn = 1'b1;
    tick();
    n_cmp++;
    if (bus_obs() !== bus_exp(1'b0, 1'b0, 1'b0, 8'h42, 32'h0) || ack_o !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_mid_setup: got %h ack %b required %h ack 00", bus_obs(), ack_o,
               bus_exp(1'b0, 1'b0, 1'b0, 8'h42, 32'h0));
    end
    tick();
    if (ack_o != 2'b00) seen++;
    tick();
    n_cmp++;
    if (cpl_obs() !== {2'b01, 1'b0, 32'h0000_4242}) begin
      n_bad++;
      $display("FAIL rst_mid_restart: got %h required %h", cpl_obs(), {2'b01, 1'b0, 32'h0000_4242});
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL rst_mid_noack: got %0d stray acks required 0", seen);
    end
    req_i = 2'b00; apb.PREADY = 1'b0;
    tick();
  endtask

  // Transaction-level model: pending set, round-robin pointer, and the
  // operands each requester posted; timing follows the 3 + wait-states rule.
  task automatic test_random();
    logic [1:0]  pend;
    logic [1:0]  m;
    logic        mlast;
    logic        wn;
    logic        e;
    logic        w [2];
    logic [8:0]  a [2];
    logic [31:0] d [2];
    logic [31:0] exp_rd;
    int          waits;
    do_reset();
    mlast = 1'b1;
    for (int r = 0; r < 60; r++) begin
      m = 2'($urandom_range(1, 3));
      for (int n = 0; n < 2; n++) begin
        w[n] = 1'($urandom);
        a[n] = 9'($urandom);
        d[n] = $urandom;
      end
      wr_i = {w[1], w[0]}; addr0_i = a[0]; addr1_i = a[1];
      wdata0_i = d[0]; wdata1_i = d[1];
      req_i = m;
      pend = m;
      while (pend != 2'b00) begin
        wn = (pend == 2'b11) ? ~mlast : pend[1];
        mlast = wn;
        tick();
        n_cmp++;
        if ({ack_o, bus_obs()} !== {2'b00, bus_exp(a[wn][8], 1'b0, w[wn], a[wn][7:0], d[wn])}) begin
          n_bad++;
          $display("FAIL rnd_setup r%0d: got %h required %h", r, {ack_o, bus_obs()},
                   {2'b00, bus_exp(a[wn][8], 1'b0, w[wn], a[wn][7:0], d[wn])});
        end
        // The winner's inputs move mid-transfer; the bus must not follow.
        if (wn) begin
          addr1_i = 9'($urandom); wdata1_i = $urandom; wr_i[1] = ~wr_i[1];
        end else begin
          addr0_i = 9'($urandom); wdata0_i = $urandom; wr_i[0] = ~wr_i[0];
        end
        waits = $urandom_range(0, 3);
        apb.PREADY = 1'b0;
        tick();
        for (int i = 0; i <= waits; i++) begin
          n_cmp++;
          if ({ack_o, bus_obs()} !== {2'b00, bus_exp(a[wn][8], 1'b1, w[wn], a[wn][7:0], d[wn])}) begin
            n_bad++;
            $display("FAIL rnd_access r%0d w%0d: got %h required %h", r, i, {ack_o, bus_obs()},
                     {2'b00, bus_exp(a[wn][8], 1'b1, w[wn], a[wn][7:0], d[wn])});
          end
          apb.PRDATA1 = $urandom; apb.PRDATA2 = $urandom;
          if (i < waits) begin
            apb.PREADY = 1'b0; apb.PSLVERR = 1'($urandom);
            tick();
          end
        end
        e = ($urandom_range(0, 3) == 0);
        apb.PREADY = 1'b1; apb.PSLVERR = e;
        exp_rd = w[wn] ? 32'd0 : (a[wn][8] ? apb.PRDATA2 : apb.PRDATA1);
        tick();
        n_cmp++;
        if (cpl_obs() !== {(wn ? 2'b10 : 2'b01), e, exp_rd}) begin
          n_bad++;
          $display("FAIL rnd_ack r%0d: got %h required %h", r, cpl_obs(), {(wn ? 2'b10 : 2'b01), e, exp_rd});
        end
        n_cmp++;
        if ({apb.PSEL1, apb.PSEL2, apb.PENABLE} !== 3'b000) begin
          n_bad++;
          $display("FAIL rnd_idle r%0d: got %b required 000", r, {apb.PSEL1, apb.PSEL2, apb.PENABLE});
        end
        apb.PREADY = 1'b0; apb.PSLVERR = 1'b0;
        pend[wn] = 1'b0;
        req_i[wn] = 1'b0;
      end
      tick();
      n_cmp++;
      if ({ack_o, apb.PSEL1, apb.PSEL2} !== 4'b0000) begin
        n_bad++;
        $display("FAIL rnd_quiet r%0d: got %b required 0000", r, {ack_o, apb.PSEL1, apb.PSEL2});
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_s1();
    test_read_wait_s2();
    test_contention();
    test_timeout();
    test_slverr();
    test_reset_mid_access();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
